axis_video_timing_tx: RTL



---
 rtl/axis_video_timing_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axis_video_timing_tx.sv
// AXI4-Stream video to raster timing front-end for the TMDS encoders.
// Tracks frame lock, flags underflow and misplaced tuser/tlast, re-locks on frame wrap.
module axis_video_timing_tx #(
    parameter int X_RES    = 1920,
    parameter int Y_RES    = 1080,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int PX_WIDTH = 10,
    parameter int CHANNELS = 3,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic                         px_clk_i,
    input  logic                         rst_n_i,
    input  logic [CHANNELS*PX_WIDTH-1:0] video_i_tdata,
    input  logic                         video_i_tvalid,
    output logic                         video_i_tready,
    input  logic                         video_i_tuser,
    input  logic                         video_i_tlast,
    output logic [CHANNELS*PX_WIDTH-1:0] px_data_o,
    output logic                         de_o,
    output logic                         hsync_o,
    output logic                         vsync_o,
    output logic                         locked_o,
    output logic                         underflow_o,
    output logic                         align_err_o
);

    localparam int H_TOTAL = X_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = Y_RES + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = CHANNELS * PX_WIDTH;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(X_RES);
    localparam logic [HW-1:0] H_EOL  = HW'(X_RES - 1);
    localparam logic [HW-1:0] H_SS   = HW'(X_RES + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(X_RES + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(Y_RES);
    localparam logic [VW-1:0] V_SS   = VW'(Y_RES + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(Y_RES + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    typedef enum logic {
        SEEK,
        LOCKED
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic h_wrap;
    logic v_wrap;
    logic active;
    logic hs_c;
    logic vs_c;
    logic sof_pos;
    logic eol_pos;
    logic misalign;
    logic tready_c;
    logic accept;
    logic underflow_c;
    logic align_c;

    assign h_wrap  = (h_cnt == H_LAST);
    assign v_wrap  = (v_cnt == V_LAST);
    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c    = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign vs_c    = (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign sof_pos = (h_cnt == '0) && (v_cnt == '0);
    assign eol_pos = (h_cnt == H_EOL);

    // Depends only on sideband bits and position, never on tvalid.
    assign misalign = active &&
                      ((video_i_tuser != sof_pos) ||
                       (video_i_tlast != eol_pos));

    always_ff @(posedge px_clk_i) begin
        if (!rst_n_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tready_c    = 1'b0;
        underflow_c = 1'b0;
        align_c     = 1'b0;
        unique case (state_q)
            SEEK: begin
                // Flush non-SOF beats; hold SOF until the frame wrap.
                tready_c = !video_i_tuser;
                if (video_i_tvalid && video_i_tuser && h_wrap && v_wrap)
                    state_d = LOCKED;
            end
            LOCKED: begin
                tready_c = active && !misalign;
                if (active && !video_i_tvalid) begin
                    underflow_c = 1'b1;
                    state_d     = SEEK;
                end else if (video_i_tvalid && misalign) begin
                    align_c = 1'b1;
                    state_d = SEEK;
                end
            end
        endcase
    end

    assign video_i_tready = rst_n_i && tready_c;
    assign accept         = video_i_tvalid && tready_c;

    always_ff @(posedge px_clk_i) begin
        if (!rst_n_i) begin
            state_q     <= SEEK;
            px_data_o   <= '0;
            de_o        <= 1'b0;
            hsync_o     <= ~HS_ON;
            vsync_o     <= ~VS_ON;
            locked_o    <= 1'b0;
            underflow_o <= 1'b0;
            align_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            de_o        <= active;
            hsync_o     <= hs_c ? HS_ON : ~HS_ON;
            vsync_o     <= vs_c ? VS_ON : ~VS_ON;
            locked_o    <= (state_q == LOCKED);
            underflow_o <= underflow_c;
            align_err_o <= align_c;
            // Beats flushed while seeking are shown as black.
            px_data_o   <= (state_q == LOCKED && accept) ?
                           video_i_tdata : DW'(0);
        end
    end

endmodule
